ads1201_frame_sequencer: RTL and testbench

Controller that sequences a bank of ADS1201 decimation-filter channels. It generates the shared Sync strobe at a programmable frame period and waits for the channels' output registers to settle. It then snapshots all channel results at once and serialises them onto a single valid/ready stream for downstream logic (FIFO, UART or bus bridge). It sits between the per-channel filters and the system data path and owns all frame timing for the ADC subsystem.

---
 rtl/ads1201_pkg.sv | 15 +
 rtl/ads1201_frame_timer.sv | 68 ++++++
 rtl/ads1201_frame_sequencer.sv | 98 +++++++++
 tb/tb_ads1201_frame_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ads1201_pkg.sv
// Shared constants and timer state encoding for the ADS1201 frame sequencer.
package ads1201_pkg;
    localparam int ADC_WORD_W = 24;
    localparam int SYNC_HIGH  = 4;
    localparam int MIN_PERIOD = 16;

    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_SYNC,
        T_SETTLE,
        T_CAPTURE,
        T_WAIT
    } timer_state_e;
endpackage

// File: rtl/ads1201_frame_timer.sv
// Frame period counter and timer FSM: drives the shared Sync strobe and a
// one-cycle Capture pulse SETTLE cycles after Sync rises.
module ads1201_frame_timer
    import ads1201_pkg::*;
#(
    parameter int SETTLE = 6
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Enable,
    input  logic [15:0] Period,
    output logic        Sync,
    output logic        Capture
);

    timer_state_e state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  per_q, per_d;
    logic [15:0]  per_clamped;
    logic [15:0]  elapsed;
    logic         sync_q, sync_d;

    always_comb begin
        per_clamped = (Period < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : Period;
        // Cycles since the START cycle; the counter was loaded with per-1 there.
        elapsed     = per_q - cnt_q - 16'd1;
        state_d     = state_q;
        per_d       = per_q;
        cnt_d       = (state_q == T_IDLE) ? '0 : cnt_q - 16'd1;

        case (state_q)
            T_IDLE:    if (Enable) state_d = T_START;
            T_START:   state_d = T_SYNC;
            T_SYNC:    if (elapsed >= 16'(SYNC_HIGH - 1)) state_d = T_SETTLE;
            T_SETTLE:  if (elapsed >= 16'(SETTLE - 1)) state_d = T_CAPTURE;
            T_CAPTURE: state_d = Enable ? T_WAIT : T_IDLE;
            T_WAIT:    if (cnt_q == '0) state_d = Enable ? T_START : T_IDLE;
            default:   state_d = T_IDLE;
        endcase

        // Period is sampled on the edge entering START so the frame length
        // counts from that edge, giving exactly per cycles START to START.
        if (state_d == T_START) begin
            per_d = per_clamped;
            cnt_d = per_clamped - 16'd1;
        end

        sync_d = (state_d == T_START) || (state_d == T_SYNC);
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= T_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            sync_q  <= sync_d;
        end
    end

    assign Sync    = sync_q;
    assign Capture = (state_q == T_CAPTURE);

endmodule

// File: rtl/ads1201_frame_sequencer.sv
// ADS1201 frame sequencer: frame timing, channel snapshot bank and a
// valid/ready stream that serialises one word per channel per frame.
module ads1201_frame_sequencer
    import ads1201_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SETTLE   = 6
) (
    input  logic                           nReset,
    input  logic                           Clk,
    input  logic                           Enable,
    input  logic [15:0]                    Period,
    output logic                           Sync,
    input  logic [ADC_WORD_W*CHANNELS-1:0] ChOutput,
    output logic [ADC_WORD_W-1:0]          Data,
    output logic [3:0]                     Channel,
    output logic                           Valid,
    input  logic                           Ready,
    output logic                           Last,
    output logic                           Overrun,
    input  logic                           ClearOverrun
);

    localparam logic [3:0] LAST_CH = 4'(CHANNELS - 1);

    logic [CHANNELS-1:0][ADC_WORD_W-1:0] shadow_q, shadow_d;
    logic                                send_q, send_d;
    logic [3:0]                          ch_q, ch_d;
    logic                                ovr_q, ovr_d;
    logic                                capture;

    ads1201_frame_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .Clk     (Clk),
        .nReset  (nReset),
        .Enable  (Enable),
        .Period  (Period),
        .Sync    (Sync),
        .Capture (capture)
    );

    always_comb begin
        shadow_d = shadow_q;
        send_d   = send_q;
        ch_d     = ch_q;
        ovr_d    = ovr_q;

        if (send_q && Ready) begin
            if (ch_q == LAST_CH) begin
                send_d = 1'b0;
                ch_d   = '0;
            end else begin
                ch_d = ch_q + 4'd1;
            end
        end

        if (ClearOverrun) ovr_d = 1'b0;

        // A frame still draining keeps its shadow; the new frame is dropped.
        if (capture) begin
            if (!send_q) begin
                shadow_d = ChOutput;
                send_d   = 1'b1;
                ch_d     = '0;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            shadow_q <= '0;
            send_q   <= 1'b0;
            ch_q     <= '0;
            ovr_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            send_q   <= send_d;
            ch_q     <= ch_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        Data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (send_q && ch_q == 4'(k)) Data = shadow_q[k];
        end
    end

    assign Valid   = send_q;
    assign Channel = ch_q;
    assign Last    = send_q && (ch_q == LAST_CH);
    assign Overrun = ovr_q;

endmodule

// File: tb/tb_ads1201_frame_sequencer.sv
// Directed bench for ads1201_frame_sequencer (CHANNELS=4, SETTLE=6).
module tb_ads1201_frame_sequencer;

    logic        Clk = 1'b0;
    logic        nReset;
    logic        Enable;
    logic [15:0] Period;
    logic        Sync;
    logic [95:0] ChOutput;
    logic [23:0] Data;
    logic [3:0]  Channel;
    logic        Valid;
    logic        Ready;
    logic        Last;
    logic        Overrun;
    logic        ClearOverrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [3:0][23:0] f1, a, b, c, d, e;
    int t0, t1, t2, t3, t4, t5, t6, tx;
    bit found;

    ads1201_frame_sequencer #(
        .CHANNELS (4),
        .SETTLE   (6)
    ) dut (
        .nReset       (nReset),
        .Clk          (Clk),
        .Enable       (Enable),
        .Period       (Period),
        .Sync         (Sync),
        .ChOutput     (ChOutput),
        .Data         (Data),
        .Channel      (Channel),
        .Valid        (Valid),
        .Ready        (Ready),
        .Last         (Last),
        .Overrun      (Overrun),
        .ClearOverrun (ClearOverrun)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Returns at the first negedge where Sync is high after having been low.
    task automatic wait_rise(output int t, output bit fnd, input int limit);
        fnd = 1'b0;
        t   = 0;
        for (int i = 0; i < limit && Sync === 1'b1; i++) @(negedge Clk);
        for (int i = 0; i < limit; i++) begin
            @(negedge Clk);
            if (Sync === 1'b1) begin
                fnd = 1'b1;
                t   = cyc;
                break;
            end
        end
    endtask

    // Called at the negedge where Sync was first seen high.
    task automatic check_frame(input logic [3:0][23:0] w, input bit drop_en);
        check("sync_rise", Sync, 1);
        for (int i = 1; i < 4; i++) begin
            @(negedge Clk);
            check("sync_high", Sync, 1);
            if (drop_en && i == 2) Enable = 1'b0;
        end
        @(negedge Clk);
        check("sync_fall", Sync, 0);
        repeat (2) @(negedge Clk);
        check("pre_valid", Valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check("valid", Valid, 1);
            check("data", Data, w[k]);
            check("channel", Channel, k);
            check("last", Last, (k == 3));
        end
        @(negedge Clk);
        check("drained", Valid, 0);
    endtask

    initial begin
        f1 = {24'd4, 24'd3, 24'd2, 24'd1};
        a  = {24'h800000, 24'h7FFFFF, 24'hFFFFFF, 24'h00A5A5};
        b  = {24'h111111, 24'h222222, 24'h333333, 24'h444444};
        c  = {24'hC00003, 24'hC00002, 24'hC00001, 24'hC00000};
        d  = {24'hD00003, 24'hD00002, 24'hD00001, 24'hD00000};
        e  = {24'hE00003, 24'hE00002, 24'hE00001, 24'hE00000};

        nReset = 1'b0; Enable = 1'b0; Period = 16'd0; Ready = 1'b0;
        ClearOverrun = 1'b0; ChOutput = '0;
        repeat (2) @(negedge Clk);
        check("rst_sync", Sync, 0);
        check("rst_valid", Valid, 0);
        check("rst_data", Data, 0);
        check("rst_channel", Channel, 0);
        check("rst_last", Last, 0);
        check("rst_overrun", Overrun, 0);

        // Basic frame, Period=512
        @(negedge Clk);
        nReset = 1'b1; Period = 16'd512; Ready = 1'b1; Enable = 1'b1; ChOutput = f1;
        wait_rise(t0, found, 600);
        check("rise0_found", found, 1);
        check_frame(f1, 1'b0);
        wait_rise(t1, found, 600);
        check("rise1_found", found, 1);
        check("period_512", t1 - t0, 512);

        // Period below minimum, effective only at the next START
        Period = 16'd5;
        wait_rise(t2, found, 600);
        check("period_hold", t2 - t1, 512);
        wait_rise(t3, found, 600);
        check("period_min", t3 - t2, 16);
        check_frame(f1, 1'b0);
        wait_rise(t4, found, 600);
        check("period_min2", t4 - t3, 16);
        check("no_overrun", Overrun, 0);

        // Backpressure across frames
        Period = 16'd512; ChOutput = a;
        wait_rise(t5, found, 600);
        check("rise5_found", found, 1);
        check("period_back", t5 - t4, 16);
        Ready = 1'b0;
        repeat (7) @(negedge Clk);
        check("bp_valid", Valid, 1);
        check("bp_data0", Data, a[0]);
        check("bp_ovr0", Overrun, 0);
        ChOutput = b;
        repeat (400) @(negedge Clk);
        check("bp_hold_valid", Valid, 1);
        check("bp_hold_data", Data, a[0]);
        check("bp_ovr1", Overrun, 0);
        repeat (123) @(negedge Clk);
        check("bp_ovr_set", Overrun, 1);
        check("bp_hold_data2", Data, a[0]);
        check("bp_hold_ch", Channel, 0);
        repeat (70) @(negedge Clk);
        check("bp_hold_data3", Data, a[0]);
        Ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge Clk);
            check("bp_data", Data, a[k]);
            check("bp_channel", Channel, k);
        end
        check("bp_last", Last, 1);
        @(negedge Clk);
        check("bp_drained", Valid, 0);

        // Overrun clear: lone pulse, then coincident with a new overrun
        ClearOverrun = 1'b1;
        @(negedge Clk);
        ClearOverrun = 1'b0;
        check("clr_lone1", Overrun, 0);
        repeat (395) @(negedge Clk);
        Ready = 1'b0;
        repeat (31) @(negedge Clk);
        check("new_valid", Valid, 1);
        check("new_data", Data, b[0]);
        check("new_ovr", Overrun, 0);
        repeat (511) @(negedge Clk);
        ClearOverrun = 1'b1;
        @(negedge Clk);
        ClearOverrun = 1'b0;
        check("clr_coincident", Overrun, 1);
        repeat (7) @(negedge Clk);
        ClearOverrun = 1'b1;
        @(negedge Clk);
        ClearOverrun = 1'b0;
        check("clr_lone2", Overrun, 0);
        Ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge Clk);
            check("b_data", Data, b[k]);
        end
        @(negedge Clk);
        check("b_drained", Valid, 0);

        // Enable dropped two cycles after START
        ChOutput = c;
        wait_rise(t6, found, 600);
        check("rise6_found", found, 1);
        check("period_512b", t6 - t5, 2048);
        check_frame(c, 1'b1);
        wait_rise(tx, found, 600);
        check("no_more_sync", found, 0);

        // Reset while Channel=2 with Sync high and Overrun set
        Period = 16'd5; Ready = 1'b1; Enable = 1'b1; ChOutput = d;
        wait_rise(tx, found, 600);
        check("rise7_found", found, 1);
        repeat (7) @(negedge Clk);
        check("d_data0", Data, d[0]);
        repeat (2) @(negedge Clk);
        check("d_ch2", Channel, 2);
        check("d_data2", Data, d[2]);
        Ready = 1'b0;
        repeat (24) @(negedge Clk);
        check("pre_rst_sync", Sync, 1);
        check("pre_rst_ovr", Overrun, 1);
        check("pre_rst_ch", Channel, 2);
        check("pre_rst_valid", Valid, 1);
        #2 nReset = 1'b0;
        #1;
        check("arst_valid", Valid, 0);
        check("arst_sync", Sync, 0);
        check("arst_ovr", Overrun, 0);
        check("arst_data", Data, 0);
        check("arst_channel", Channel, 0);
        check("arst_last", Last, 0);
        @(negedge Clk);
        nReset = 1'b1; Ready = 1'b1; ChOutput = e;
        wait_rise(tx, found, 600);
        check("rise8_found", found, 1);
        check_frame(e, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
